// File: rtl/sr_cpu_pkg.sv
// Shared definitions for the schoolRISCV front end: opcodes, function fields,
// ALU control codes and the decoded control bundle.
package sr_cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_SRL  = 3'b010,
        ALU_SLTU = 3'b011,
        ALU_SUB  = 3'b100
    } aluCtl_e;

    typedef struct packed {
        logic    regWrite;
        logic    aluSrc;
        logic    wdSrc;
        logic    branch;
        logic    condZero;
        aluCtl_e aluControl;
    } ctrl_t;

endpackage

// File: rtl/sr_alu.sv
// Combinational ALU for the execute stage: ADD, SUB, OR, SRL, SLTU plus a
// zero flag used by branch resolution.
module sr_alu
    import sr_cpu_pkg::*;
(
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic [2:0]  aluControl,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = 32'd0;
        case (aluControl)
            ALU_ADD:  result = srcA + srcB;
            ALU_SUB:  result = srcA - srcB;
            ALU_OR:   result = srcA | srcB;
            ALU_SRL:  result = srcA >> srcB[4:0];
            ALU_SLTU: result = {31'd0, srcA < srcB};
            default:  result = 32'd0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/sr_fde_pipeline.sv
// Fetch, decode and execute stages of the schoolRISCV pipelined core with the
// F/D, D/E and E/W registers. Next-PC, hazard and forwarding logic live outside.
module sr_fde_pipeline
    import sr_cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic [31:0] imAddr,
    input  logic [31:0] imData,
    input  logic        freeze,
    output logic [31:0] pcPlus4_f,
    input  logic [31:0] srcA_i,
    input  logic [31:0] srcB_i,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic        branch_d,
    output logic        wdSrc_o,
    output logic        regWrite_o,
    output logic        branch_o,
    output logic        condZero_o,
    output logic        aluZero_o,
    output logic [31:0] aluResult_o,
    output logic [31:0] immU_o,
    output logic [31:0] pcBranch_o,
    output logic [31:0] pcPlus4_o,
    output logic [4:0]  rd_o
);

    logic [31:0] instrF, pcF, pcPlus4F;

    assign imAddr    = pc_i;
    assign pcPlus4_f = pcPlus4F;

    // NOTE: all state uses nonblocking assignments so every stage samples the
    // previous stage's value from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instrF   <= INSTR_NOP;
            pcF      <= '0;
            pcPlus4F <= '0;
        end else begin
            instrF   <= imData;
            pcF      <= pc_i;
            pcPlus4F <= pc_i + 32'd4;
        end
    end

    logic [6:0]  opcodeD, funct7D;
    logic [2:0]  funct3D;
    logic [4:0]  rdD;
    logic [31:0] immID, immBD, immUD;
    ctrl_t       ctrlD;

    assign opcodeD = instrF[6:0];
    assign rdD     = instrF[11:7];
    assign funct3D = instrF[14:12];
    assign funct7D = instrF[31:25];
    assign immID   = {{20{instrF[31]}}, instrF[31:20]};
    assign immBD   = {{19{instrF[31]}}, instrF[31], instrF[7], instrF[30:25], instrF[11:8], 1'b0};
    assign immUD   = {instrF[31:12], 12'd0};

    // NOTE: ctrlD gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        ctrlD = '0;
        case (opcodeD)
            OP_R: if (rdD != 5'd0) begin
                ctrlD.regWrite = 1'b1;
                case ({funct7D, funct3D})
                    {F7_ADD, F3_ADD}:  ctrlD.aluControl = ALU_ADD;
                    {F7_SUB, F3_ADD}:  ctrlD.aluControl = ALU_SUB;
                    {F7_ADD, F3_OR}:   ctrlD.aluControl = ALU_OR;
                    {F7_ADD, F3_SRL}:  ctrlD.aluControl = ALU_SRL;
                    {F7_ADD, F3_SLTU}: ctrlD.aluControl = ALU_SLTU;
                    default:           ctrlD = '0;
                endcase
            end
            OP_IMM: if (rdD != 5'd0 && funct3D == F3_ADD) begin
                ctrlD.regWrite   = 1'b1;
                ctrlD.aluSrc     = 1'b1;
                ctrlD.aluControl = ALU_ADD;
            end
            OP_LUI: if (rdD != 5'd0) begin
                ctrlD.regWrite = 1'b1;
                ctrlD.wdSrc    = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3D == F3_BEQ || funct3D == F3_BNE) begin
                    ctrlD.branch     = 1'b1;
                    ctrlD.condZero   = (funct3D == F3_BEQ);
                    ctrlD.aluControl = ALU_SUB;
                end
            end
            default: ctrlD = '0;
        endcase
    end

    ctrl_t       ctrlE;
    logic [4:0]  rdE;
    logic [31:0] immIE, immUE, pcBranchE, pcPlus4E;

    // A frozen decode slot becomes a full bubble, data fields included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || freeze) begin
            ctrlE     <= '0;
            rs1_o     <= '0;
            rs2_o     <= '0;
            rdE       <= '0;
            immIE     <= '0;
            immUE     <= '0;
            pcBranchE <= '0;
            pcPlus4E  <= '0;
        end else begin
            ctrlE     <= ctrlD;
            rs1_o     <= instrF[19:15];
            rs2_o     <= instrF[24:20];
            rdE       <= rdD;
            immIE     <= immID;
            immUE     <= immUD;
            pcBranchE <= pcF + immBD;
            pcPlus4E  <= pcPlus4F;
        end
    end

    assign branch_d = ctrlE.branch;

    logic [31:0] srcBE, aluResultE;
    logic        aluZeroE, validE;

    assign srcBE  = ctrlE.aluSrc ? immIE : srcB_i;
    assign validE = ctrlE.regWrite | ctrlE.branch;

    sr_alu u_alu (
        .srcA       (srcA_i),
        .srcB       (srcBE),
        .aluControl (ctrlE.aluControl),
        .result     (aluResultE),
        .zero       (aluZeroE)
    );

    // Bubbles carry a zero result and flag so an idle stage reads all-zero,
    // exactly as it does straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdSrc_o     <= 1'b0;
            regWrite_o  <= 1'b0;
            branch_o    <= 1'b0;
            condZero_o  <= 1'b0;
            aluZero_o   <= 1'b0;
            aluResult_o <= '0;
            rd_o        <= '0;
            immU_o      <= '0;
            pcBranch_o  <= '0;
            pcPlus4_o   <= '0;
        end else begin
            wdSrc_o     <= ctrlE.wdSrc;
            regWrite_o  <= ctrlE.regWrite;
            branch_o    <= ctrlE.branch;
            condZero_o  <= ctrlE.condZero;
            aluZero_o   <= validE & aluZeroE;
            aluResult_o <= validE ? aluResultE : 32'd0;
            rd_o        <= rdE;
            immU_o      <= immUE;
            pcBranch_o  <= pcBranchE;
            pcPlus4_o   <= pcPlus4E;
        end
    end

endmodule

// File: tb/tb_sr_fde_pipeline.sv
// Self-checking bench for sr_fde_pipeline: directed scenarios plus a randomized
// instruction stream compared against an instruction-level reference model.
module tb_sr_fde_pipeline;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i, imAddr, imData, pcPlus4_f, srcA_i, srcB_i;
    logic        freeze, branch_d;
    logic [4:0]  rs1_o, rs2_o, rd_o;
    logic        wdSrc_o, regWrite_o, branch_o, condZero_o, aluZero_o;
    logic [31:0] aluResult_o, immU_o, pcBranch_o, pcPlus4_o;

    sr_fde_pipeline dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_i        (pc_i),
        .imAddr      (imAddr),
        .imData      (imData),
        .freeze      (freeze),
        .pcPlus4_f   (pcPlus4_f),
        .srcA_i      (srcA_i),
        .srcB_i      (srcB_i),
        .rs1_o       (rs1_o),
        .rs2_o       (rs2_o),
        .branch_d    (branch_d),
        .wdSrc_o     (wdSrc_o),
        .regWrite_o  (regWrite_o),
        .branch_o    (branch_o),
        .condZero_o  (condZero_o),
        .aluZero_o   (aluZero_o),
        .aluResult_o (aluResult_o),
        .immU_o      (immU_o),
        .pcBranch_o  (pcBranch_o),
        .pcPlus4_o   (pcPlus4_o),
        .rd_o        (rd_o)
    );

    always #5 clk = ~clk;

    int passCnt = 0;
    int checkCnt = 0;

    // History of the last three fetches; index 0 is the most recent edge.
    logic [31:0] hIns [3];
    logic [31:0] hPc  [3];
    logic        hFrz [2];
    logic [31:0] hA, hB;

    typedef enum {K_BUBBLE, K_ADD, K_SUB, K_OR, K_SRL, K_SLTU, K_ADDI, K_LUI, K_BEQ, K_BNE} kind_e;

    typedef struct packed {
        logic        regWrite;
        logic        wdSrc;
        logic        branch;
        logic        condZero;
        logic [4:0]  rd;
        logic [31:0] immU;
        logic [31:0] pcBranch;
        logic [31:0] pcPlus4;
    } ewCore_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic kind_e classify(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       rdZero;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        rdZero = (w[11:7] == 5'd0);
        if (op == 7'h33 && !rdZero) begin
            if (f7 == 7'h00 && f3 == 3'd0) return K_ADD;
            if (f7 == 7'h20 && f3 == 3'd0) return K_SUB;
            if (f7 == 7'h00 && f3 == 3'd6) return K_OR;
            if (f7 == 7'h00 && f3 == 3'd5) return K_SRL;
            if (f7 == 7'h00 && f3 == 3'd3) return K_SLTU;
        end
        if (op == 7'h13 && !rdZero && f3 == 3'd0) return K_ADDI;
        if (op == 7'h37 && !rdZero) return K_LUI;
        if (op == 7'h63 && f3 == 3'd0) return K_BEQ;
        if (op == 7'h63 && f3 == 3'd1) return K_BNE;
        return K_BUBBLE;
    endfunction

    function automatic ewCore_t modelCore(input logic [31:0] w, input logic [31:0] pc, input logic frz);
        ewCore_t e;
        kind_e   k;
        logic [31:0] immB;
        e = '0;
        if (frz) return e;
        k = classify(w);
        immB = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        e.rd       = w[11:7];
        e.immU     = {w[31:12], 12'd0};
        e.pcBranch = pc + immB;
        e.pcPlus4  = pc + 32'd4;
        e.regWrite = (k inside {K_ADD, K_SUB, K_OR, K_SRL, K_SLTU, K_ADDI, K_LUI});
        e.wdSrc    = (k == K_LUI);
        e.branch   = (k inside {K_BEQ, K_BNE});
        e.condZero = (k == K_BEQ);
        return e;
    endfunction

    // Returns {zero, result}; a bubble reads as zero result and zero flag.
    function automatic logic [32:0] modelAlu(input logic [31:0] w, input logic frz,
                                             input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [31:0] immI;
        kind_e k;
        k = frz ? K_BUBBLE : classify(w);
        immI = {{20{w[31]}}, w[31:20]};
        case (k)
            K_ADD:        r = a + b;
            K_SUB, K_BEQ, K_BNE: r = a - b;
            K_OR:         r = a | b;
            K_SRL:        r = a >> b[4:0];
            K_SLTU:       r = (a < b) ? 32'd1 : 32'd0;
            K_ADDI:       r = a + immI;
            default:      r = 32'd0;
        endcase
        if (k == K_BUBBLE) return 33'd0;
        return {r == 32'd0, r};
    endfunction

    function automatic logic [31:0] encB(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] randInstr();
        logic [4:0]  rs1, rs2, rd;
        logic [11:0] imm12;
        logic [31:0] w;
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        rd  = 5'($urandom_range(1, 31));
        imm12 = 12'($urandom);
        case ($urandom_range(0, 11))
            0:  w = {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
            1:  w = {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
            2:  w = {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
            3:  w = {7'h00, rs2, rs1, 3'd5, rd, 7'h33};
            4:  w = {7'h00, rs2, rs1, 3'd3, rd, 7'h33};
            5:  w = {imm12, rs1, 3'd0, rd, 7'h13};
            6:  w = {20'($urandom), rd, 7'h37};
            7:  w = encB(13'($urandom), rs2, rs1, 3'd0);
            8:  w = encB(13'($urandom), rs2, rs1, 3'd1);
            9:  w = ($urandom_range(0, 1) == 0) ? {imm12, rs1, 3'd0, 5'd0, 7'h13}
                                                : {7'h00, rs2, rs1, 3'd0, 5'd0, 7'h33};
            10: w = ($urandom_range(0, 1) == 0) ? encB(13'($urandom), rs2, rs1, 3'd4)
                                                : {imm12, rs1, 3'd4, rd, 7'h13};
            default: w = {25'($urandom), 7'h03};
        endcase
        return w;
    endfunction

    task automatic step(input logic [31:0] ins, input logic [31:0] pc, input logic frz,
                        input logic [31:0] a, input logic [31:0] b);
        imData = ins;
        pc_i   = pc;
        freeze = frz;
        srcA_i = a;
        srcB_i = b;
        #1;
        checkCnt++;
        if (imAddr !== pc) $display("FAIL imAddr: got %h expected %h", imAddr, pc);
        else passCnt++;
        @(posedge clk);
        #1;
        hIns[2] = hIns[1]; hIns[1] = hIns[0]; hIns[0] = ins;
        hPc[2]  = hPc[1];  hPc[1]  = hPc[0];  hPc[0]  = pc;
        hFrz[1] = hFrz[0]; hFrz[0] = frz;
        hA = a;
        hB = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imData = 32'd0; pc_i = 32'd0; freeze = 1'b0; srcA_i = 32'd0; srcB_i = 32'd0;
        #12;
        checkCnt++;
        if ({regWrite_o, branch_o, wdSrc_o, aluZero_o, aluResult_o, rd_o, pcPlus4_f, pcBranch_o} !== '0)
            $display("FAIL reset_hold: got rw=%b br=%b alu=%h rd=%0d pc4f=%h expected all 0",
                     regWrite_o, branch_o, aluResult_o, rd_o, pcPlus4_f);
        else passCnt++;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
            checkCnt++;
            if ({regWrite_o, branch_o, aluResult_o} !== '0)
                $display("FAIL reset_idle[%0d]: got rw=%b br=%b alu=%h expected 0 0 0",
                         i, regWrite_o, branch_o, aluResult_o);
            else passCnt++;
        end
    endtask

    task automatic test_addi();
        step(32'h0050_0093, 32'h0, 1'b0, 32'd0, 32'd0);
        step(NOP, 32'h4, 1'b0, 32'd0, 32'd0);
        checkCnt++;
        if (rs1_o !== 5'd0) $display("FAIL addi_rs1: got %0d expected 0", rs1_o);
        else passCnt++;
        step(NOP, 32'h8, 1'b0, 32'd0, 32'd0);
        checkCnt++;
        if ({aluResult_o, rd_o, regWrite_o, wdSrc_o} !== {32'd5, 5'd1, 1'b1, 1'b0})
            $display("FAIL addi: got alu=%h rd=%0d rw=%b wd=%b expected 5 1 1 0",
                     aluResult_o, rd_o, regWrite_o, wdSrc_o);
        else passCnt++;
    endtask

    task automatic test_sub_wrap();
        step(32'h4020_81B3, 32'h20, 1'b0, 32'd0, 32'd0);
        step(NOP, 32'h24, 1'b0, 32'd0, 32'd0);
        checkCnt++;
        if ({rs1_o, rs2_o} !== {5'd1, 5'd2}) $display("FAIL sub_srcs: got %0d %0d expected 1 2", rs1_o, rs2_o);
        else passCnt++;
        step(NOP, 32'h28, 1'b0, 32'd0, 32'd1);
        checkCnt++;
        if ({aluResult_o, aluZero_o, rd_o} !== {32'hFFFF_FFFF, 1'b0, 5'd3})
            $display("FAIL sub_wrap: got alu=%h z=%b rd=%0d expected ffffffff 0 3", aluResult_o, aluZero_o, rd_o);
        else passCnt++;
    endtask

    task automatic test_back_to_back();
        step(32'h0020_D233, 32'h30, 1'b0, 32'd0, 32'd0);
        step(32'h0020_B233, 32'h34, 1'b0, 32'd0, 32'd0);
        step(NOP, 32'h38, 1'b0, 32'h8000_0000, 32'd31);
        checkCnt++;
        if (aluResult_o !== 32'd1) $display("FAIL srl: got %h expected 1", aluResult_o);
        else passCnt++;
        step(NOP, 32'h3C, 1'b0, 32'd1, 32'hFFFF_FFFF);
        checkCnt++;
        if (aluResult_o !== 32'd1) $display("FAIL sltu: got %h expected 1", aluResult_o);
        else passCnt++;
    endtask

    task automatic test_lui();
        step(32'h1234_52B7, 32'h40, 1'b0, 32'd0, 32'd0);
        step(NOP, 32'h44, 1'b0, 32'd0, 32'd0);
        step(NOP, 32'h48, 1'b0, 32'd0, 32'd0);
        checkCnt++;
        if ({immU_o, wdSrc_o, regWrite_o, rd_o} !== {32'h1234_5000, 1'b1, 1'b1, 5'd5})
            $display("FAIL lui: got immU=%h wd=%b rw=%b rd=%0d expected 12345000 1 1 5",
                     immU_o, wdSrc_o, regWrite_o, rd_o);
        else passCnt++;
    endtask

    task automatic test_branch_freeze();
        step(32'h0020_8463, 32'h10, 1'b0, 32'd0, 32'd0);
        step(NOP, 32'h14, 1'b0, 32'd0, 32'd0);
        checkCnt++;
        if (branch_d !== 1'b1) $display("FAIL beq_branch_d: got %b expected 1", branch_d);
        else passCnt++;
        step(NOP, 32'h18, 1'b0, 32'd7, 32'd7);
        checkCnt++;
        if ({branch_o, condZero_o, aluZero_o, regWrite_o, pcBranch_o, pcPlus4_o} !==
            {1'b1, 1'b1, 1'b1, 1'b0, 32'h18, 32'h14})
            $display("FAIL beq: got br=%b cz=%b z=%b rw=%b pcB=%h pc4=%h expected 1 1 1 0 18 14",
                     branch_o, condZero_o, aluZero_o, regWrite_o, pcBranch_o, pcPlus4_o);
        else passCnt++;
        step(32'h0020_8463, 32'h10, 1'b0, 32'd0, 32'd0);
        step(NOP, 32'h14, 1'b1, 32'd0, 32'd0);
        checkCnt++;
        if ({branch_d, rs1_o, rs2_o, pcPlus4_f} !== {1'b0, 5'd0, 5'd0, 32'h18})
            $display("FAIL freeze_de: got br_d=%b rs1=%0d rs2=%0d pc4f=%h expected 0 0 0 18",
                     branch_d, rs1_o, rs2_o, pcPlus4_f);
        else passCnt++;
        step(NOP, 32'h18, 1'b0, 32'd7, 32'd7);
        checkCnt++;
        if ({branch_o, regWrite_o, pcBranch_o} !== {1'b0, 1'b0, 32'd0})
            $display("FAIL freeze_ew: got br=%b rw=%b pcB=%h expected 0 0 0", branch_o, regWrite_o, pcBranch_o);
        else passCnt++;
    endtask

    task automatic test_random(input int n);
        logic [31:0] ins, pc, a, b;
        logic        frz;
        ewCore_t     expCore, actCore;
        logic [32:0] expAlu;
        logic [10:0] expDe;
        for (int i = 0; i < n; i++) begin
            ins = randInstr();
            pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            frz = ($urandom_range(0, 5) == 0);
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            step(ins, pc, frz, a, b);
            if (i >= 2) begin
                expCore = modelCore(hIns[2], hPc[2], hFrz[1]);
                actCore = {regWrite_o, wdSrc_o, branch_o, condZero_o, rd_o, immU_o, pcBranch_o, pcPlus4_o};
                checkCnt++;
                if (actCore !== expCore)
                    $display("FAIL rand_ew[%0d] ins=%h: got %h expected %h", i, hIns[2], actCore, expCore);
                else passCnt++;
                if (hFrz[1] || classify(hIns[2]) != K_LUI) begin
                    expAlu = modelAlu(hIns[2], hFrz[1], hA, hB);
                    checkCnt++;
                    if ({aluZero_o, aluResult_o} !== expAlu)
                        $display("FAIL rand_alu[%0d] ins=%h a=%h b=%h: got %h expected %h",
                                 i, hIns[2], hA, hB, {aluZero_o, aluResult_o}, expAlu);
                    else passCnt++;
                end
                expDe = hFrz[0] ? 11'd0 : {hIns[1][19:15], hIns[1][24:20],
                                           classify(hIns[1]) inside {K_BEQ, K_BNE}};
                checkCnt++;
                if ({rs1_o, rs2_o, branch_d} !== expDe)
                    $display("FAIL rand_de[%0d] ins=%h: got %h expected %h", i, hIns[1], {rs1_o, rs2_o, branch_d}, expDe);
                else passCnt++;
                checkCnt++;
                if (pcPlus4_f !== hPc[0] + 32'd4)
                    $display("FAIL rand_pc4f[%0d]: got %h expected %h", i, pcPlus4_f, hPc[0] + 32'd4);
                else passCnt++;
            end
        end
    endtask

    task automatic test_reset_flush();
        test_random(6);
        #2;
        rst_n = 1'b0;
        #1;
        checkCnt++;
        if ({regWrite_o, branch_o, wdSrc_o, condZero_o, aluZero_o, aluResult_o, rd_o,
             pcPlus4_f, pcBranch_o, pcPlus4_o, immU_o, rs1_o, rs2_o, branch_d} !== '0)
            $display("FAIL reset_flush: got rw=%b br=%b alu=%h rd=%0d pc4f=%h pcB=%h expected all 0",
                     regWrite_o, branch_o, aluResult_o, rd_o, pcPlus4_f, pcBranch_o);
        else passCnt++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        hIns = '{default: NOP};
        hPc  = '{default: 32'd0};
        hFrz = '{default: 1'b0};
        hA = 32'd0;
        hB = 32'd0;
        test_reset();
        test_addi();
        test_sub_wrap();
        test_back_to_back();
        test_lui();
        test_branch_freeze();
        test_random(400);
        test_reset_flush();
        test_random(200);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/sr_fde_pipeline.md
# sr_fde_pipeline

Front three stages of the schoolRISCV pipelined core: fetch, decode and execute, each separated by a pipeline register. The external next-PC / hazard logic supplies the fetch PC, forwarded operands and a freeze request. The block drives instruction memory, register-file read addresses, and the execute-stage (E/W) bundle consumed by writeback and the register file.

## Interface
No parameters.
- clk  in  1  core clock, all registers on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pc_i  in  32  PC to fetch this cycle (from next-PC logic)
- imAddr  out  32  instruction memory address; equals pc_i combinationally
- imData  in  32  instruction word at imAddr, same cycle
- freeze  in  1  when 1, the D/E register loads a bubble
- pcPlus4_f  out  32  F/D register's PC+4, for next-PC selection
- srcA_i, srcB_i  in  32 each  forwarded rs1/rs2 values for the instruction in execute
- rs1_o, rs2_o  out  5 each  D/E source register indices, for register-file read and forwarding
- branch_d  out  1  D/E branch flag, for the hazard unit
- wdSrc_o, regWrite_o, branch_o, condZero_o, aluZero_o  out  1 each  E/W control bundle
- aluResult_o, immU_o, pcBranch_o, pcPlus4_o  out  32 each  E/W data bundle
- rd_o  out  5  E/W destination register

## Operation
- **Fetch (F/D register).** Captures imData, pc_i, and pc_i+4 (mod 2^32).
- **Decode.** Combinationally decodes the F/D instruction, then registers the result into D/E: controls, rs1=[19:15], rs2=[24:20], rd=[11:7], immI, immU, pcBranch = pc + immB, and pcPlus4.
- **Immediates.**
  - immI = sign-extended [31:20].
  - immB = sign-extended {[31],[7],[30:25],[11:8],0}.
  - immU = {[31:12], 12'b0}.
- **Supported instructions.** Any other encoding (including x0 writes) decodes as a bubble: all control bits 0.
  - R-type (opcode 0110011): ADD (f3 000, f7 0), SUB (f3 000, f7 0100000), OR (110), SRL (101), SLTU (011). regWrite=1.
  - ADDI (0010011, f3 000): aluSrc=1, regWrite=1, ADD.
  - LUI (0110111): wdSrc=1, regWrite=1.
  - BEQ (1100011, f3 000): branch=1, condZero=1, SUB.
  - BNE (f3 001): branch=1, condZero=0, SUB.
- **aluControl encoding.** ADD 000, OR 001, SRL 010, SLTU 011, SUB 100.
- **Execute (E/W register).**
  - B = aluSrc ? immI : srcB_i.
  - ALU operations:
    - ADD/SUB: wrap modulo 2^32.
    - SRL: logical shift of srcA_i by B[4:0].
    - SLTU: unsigned compare, result 0 or 1.
  - aluZero = (result == 0).
  - E/W registers all controls, aluResult, rd, immU, pcBranch and pcPlus4.
- **freeze.** D/E captures a bubble: all controls 0, data fields don't-care but driven as 0. F/D still captures normally, and E/W advances.

## Timing
- Reset (asynchronous, rst_n=0):
  - All pipeline registers clear to 0.
  - The F/D instruction resets to 0x00000013 (NOP), so decode yields a bubble.
  - All outputs except imAddr read 0 during and after reset until new data flows.
- Latency: an instruction fetched at edge N is in D/E after edge N+1 and in E/W after edge N+2.
- rs1_o/rs2_o are valid from D/E during the cycle srcA_i/srcB_i are sampled; forwarding is external and combinational.
- A bubble propagates: regWrite_o=0 and branch_o=0 one cycle later.
- Reset asserted mid-operation flushes all stages immediately.

## Structure
- Shared package sr_cpu_pkg holds:
  - opcode, funct3 and funct7 constants;
  - ALU control codes;
  - NOP constant 0x00000013.
- One sub-module, sr_alu (combinational: srcA, srcB, aluControl → result, zero).
- Stage registers live in the top module.

## Test plan
- **Reset.** rst_n=0 then release, imData=0 → regWrite_o=0, branch_o=0, aluResult_o=0 for 3 cycles.
- **ADDI.** ADDI x1,x0,5 (0x00500093), srcA_i=0 → two edges later aluResult_o=5, rd_o=1, regWrite_o=1, wdSrc_o=0.
- **SUB wrap.** SUB x3,x1,x2 with srcA_i=0, srcB_i=1 → aluResult_o=0xFFFFFFFF, aluZero_o=0.
- **SRL and SLTU.** SRL with srcA_i=0x80000000, srcB_i=31 → aluResult_o=1. SLTU with srcA_i=1, srcB_i=0xFFFFFFFF → aluResult_o=1.
- **LUI.** LUI x5,0x12345 → immU_o=0x12345000, wdSrc_o=1, regWrite_o=1.
- **Branch and freeze.** BEQ at pc 0x10 with offset +8 and srcA_i=srcB_i=7 → branch_d=1, then branch_o=1, condZero_o=1, aluZero_o=1, pcBranch_o=0x18. Same instruction with freeze=1 at its decode edge → branch_o=0, regWrite_o=0.
